mux_scan_sequencer: RTL and testbench
=====================================

Name: mux_scan_sequencer

Overview:
- Control stage directly upstream of the recursive N:1 bit mux: drives its select bus and consumes its 1-bit output.
- On `start`, scans every enabled channel in ascending index order. Each sampled bit is presented on a valid/ready stream and also accumulated into a parallel frame word.
- Lets a single shared mux tree serve N inputs as a sequenced, back-pressurable sample stream.

Parameters:
- N, 8, number of mux inputs. Power of two, ≥2.
- M, $clog2(N), select width. Must equal the mux's select width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  scan request; accepted only in IDLE.
- chan_mask  in  N  per-channel enable; sampled on start acceptance.
- sel  out  M  registered select to the mux.
- mux_out  in  1  mux output; combinational function of sel.
- sample_valid  out  1  captured sample available.
- sample_ready  in  1  downstream accepts the sample.
- sample_chan  out  M  channel index of the current sample.
- sample_bit  out  1  captured mux_out value.
- frame  out  N  accumulated samples; bit i = channel i.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at scan completion.

Behaviour:
- Reset (rst_n=0 at a clk edge) overrides everything:
  - state=IDLE; sel=0; sample_valid=0; sample_chan=0; sample_bit=0; frame=0; busy=0; done=0.
  - Reset mid-scan aborts silently: no done pulse, sample discarded.
- States and transitions:
  - IDLE → SELECT: on start=1 with chan_mask≠0.
    - Latch mask, clear frame to 0, set sel = lowest set mask bit.
  - IDLE → FINISH: on start=1 with chan_mask=0.
    - Clear frame; no sample emitted.
  - SELECT (one cycle, mux settles) → PRESENT:
    - At the edge leaving SELECT: sample_bit←mux_out, sample_chan←sel, frame[sel]←mux_out, sample_valid←1.
  - PRESENT: hold sample_valid, sample_bit and sample_chan stable until sample_valid & sample_ready at an edge. On that handshake:
    - if a latched mask bit exists above sample_chan: sel←that index, sample_valid←0, go to SELECT;
    - else: sample_valid←0, go to FINISH.
  - FINISH (one cycle): done=1 in this cycle only, then IDLE. busy stays high in FINISH.
- start is ignored while busy (includes FINISH). chan_mask changes mid-scan have no effect.
- sel is registered and changes only on entry to SELECT. In IDLE, sel holds its last value. sel is never driven to a disabled channel during a scan.
- Latency, with sample_ready held at 1:
  - start accepted at edge k → sel valid after k.
  - First sample_valid after edge k+1.
  - 2 cycles per enabled channel; done high in the cycle after the final handshake edge.
  - Full-mask scan: done asserted 2N cycles after the start edge.
- Back-pressure: sample_ready=0 stalls indefinitely in PRESENT; no sample is lost or duplicated.
- frame:
  - Bits of disabled channels read 0.
  - Enabled bits update at capture, so partial results are visible mid-scan.
  - frame holds after done until the next accepted start.
- Boundaries:
  - Only channel N-1 enabled: single sample, sel=N-1.
  - Only channel 0 enabled: sel=0.
  - N=2: M=1; both channels work.
  - Index arithmetic is M bits wide and never wraps. The search for the next channel considers only indices strictly greater than the current one.

Decomposition:
- Package mux_scan_pkg: state enum (IDLE, SELECT, PRESENT, FINISH) and a localparam for per-channel cycle cost (2).
- Sub-module mux_next_chan (combinational, parameter N):
  - Inputs: mask, current index, include_current flag.
  - Outputs: next index and found flag.
  - Used both for the first channel (include_current=1, index 0) and for subsequent channels.

Test Plan:
- Reset then start with mask=8'hFF, inp=8'hA5 on the mux, ready=1 → samples ch0..7 with bits 1,0,1,0,0,1,0,1; frame=8'hA5; done pulse at cycle 16 after start.
- mask=8'b1001_0010, inp=8'hFF → only ch1, ch4, ch7 emitted, sel never equals another channel; frame=8'h92.
- mask=0 with start → no sample_valid; done pulses the cycle after the start edge; frame=0.
- ch2 sample with ready held low 5 cycles → sample_valid, sample_chan and sample_bit stable for 5 cycles; exactly one handshake; next sel=3.
- start re-pulsed mid-scan → ignored, same sample sequence. rst_n low for 1 cycle during ch3 → all outputs 0, no done pulse, next start works normally.
- N=2 instance, mask=2'b10, inp=2'b10 → single sample ch1 with bit 1; frame=2'b10.

Source files
------------

// File: rtl/mux_scan_sequencer_pkg.sv
// Shared definitions for the mux scan sequencer: FSM state codes and per-channel cycle cost.
package mux_scan_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SELECT  = 2'd1;
    localparam logic [1:0] PRESENT = 2'd2;
    localparam logic [1:0] FINISH  = 2'd3;

    // One settle cycle plus one present cycle per enabled channel (with ready held high).
    localparam int CHAN_CYCLES = 2;

endpackage

// File: rtl/mux_scan_sequencer_if.sv
// Bundle between the scan sequencer and its environment: control, mux select/output,
// and the valid/ready sample stream.
interface mux_scan_sequencer_if #(
    parameter int N = 8,
    parameter int M = $clog2(N)
);
    logic         start;
    logic [N-1:0] chan_mask;
    logic [M-1:0] sel;
    logic         mux_out;
    logic         sample_valid;
    logic         sample_ready;
    logic [M-1:0] sample_chan;
    logic         sample_bit;
    logic [N-1:0] frame;
    logic         busy;
    logic         done;

    modport master (
        input  start, chan_mask, mux_out, sample_ready,
        output sel, sample_valid, sample_chan, sample_bit, frame, busy, done
    );

    modport slave (
        output start, chan_mask, mux_out, sample_ready,
        input  sel, sample_valid, sample_chan, sample_bit, frame, busy, done
    );
endinterface

// File: rtl/mux_scan_sequencer_next_chan.sv
// Finds the lowest set mask bit above the current index (or at it when include_current is set).
// Purely combinational, no latency, no backpressure.
module mux_next_chan #(
    parameter int N = 8,
    parameter int M = $clog2(N)
) (
    input  logic [N-1:0] mask,
    input  logic [M-1:0] cur,
    input  logic         include_current,
    output logic [M-1:0] nxt,
    output logic         found
);

    // Descending walk so the last hit, i.e. the lowest qualifying index, wins.
    always_comb begin
        nxt   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i] && ((i > int'(cur)) || (include_current && (i == int'(cur))))) begin
                nxt   = M'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Sequences a shared N:1 bit mux over the enabled channels; 2 cycles per channel, done 1 cycle later.
// Each sample is held on the valid/ready stream until accepted; ready low stalls indefinitely.
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int N = 8,
    parameter int M = $clog2(N)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mux_scan_sequencer_if.master   bus
);

    logic [1:0]   state;
    logic [N-1:0] mask_q;
    logic [M-1:0] sel_q;
    logic         valid_q;
    logic [M-1:0] chan_q;
    logic         bit_q;
    logic [N-1:0] frame_q;

    logic [N-1:0] srch_mask;
    logic [M-1:0] srch_cur;
    logic         srch_incl;
    logic [M-1:0] srch_nxt;
    logic         srch_found;

    // One search unit: first channel from the live mask in IDLE, successor from the latched mask later.
    always_comb begin
        srch_mask = mask_q;
        srch_cur  = chan_q;
        srch_incl = 1'b0;
        if (state == IDLE) begin
            srch_mask = bus.chan_mask;
            srch_cur  = '0;
            srch_incl = 1'b1;
        end
    end

    mux_next_chan #(.N(N), .M(M)) u_next_chan (
        .mask            (srch_mask),
        .cur             (srch_cur),
        .include_current (srch_incl),
        .nxt             (srch_nxt),
        .found           (srch_found)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            mask_q  <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            chan_q  <= '0;
            bit_q   <= 1'b0;
            frame_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mask_q  <= bus.chan_mask;
                        frame_q <= '0;
                        if (srch_found) begin
                            sel_q <= srch_nxt;
                            state <= SELECT;
                        end else begin
                            state <= FINISH;
                        end
                    end
                end
                SELECT: begin
                    bit_q          <= bus.mux_out;
                    chan_q         <= sel_q;
                    frame_q[sel_q] <= bus.mux_out;
                    valid_q        <= 1'b1;
                    state          <= PRESENT;
                end
                PRESENT: begin
                    if (bus.sample_ready) begin
                        valid_q <= 1'b0;
                        if (srch_found) begin
                            sel_q <= srch_nxt;
                            state <= SELECT;
                        end else begin
                            state <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.sel          = sel_q;
    assign bus.sample_valid = valid_q;
    assign bus.sample_chan  = chan_q;
    assign bus.sample_bit   = bit_q;
    assign bus.frame        = frame_q;
    assign bus.busy         = (state != IDLE);
    assign bus.done         = (state == FINISH);

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: directed and randomized scans against a queue-based expectation model.
module tb_mux_scan_sequencer;
    import mux_scan_pkg::*;

    logic clk;
    logic rst_n;
    logic [7:0] inp;
    logic [1:0] inp2;
    int tests;
    int fails;

    mux_scan_sequencer_if #(.N(8)) bus ();
    mux_scan_sequencer_if #(.N(2)) bus2 ();

    mux_scan_sequencer #(.N(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    mux_scan_sequencer #(.N(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    assign bus.mux_out  = inp[bus.sel];
    assign bus2.mux_out = inp2[bus2.sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One complete scan on the N=8 instance; rmode 1 randomizes ready, stall_chan gets 5 held-low cycles.
    task automatic run_scan(input logic [7:0] mask, input logic [7:0] in_v, input int rmode,
                            input int stall_chan, input bit repulse);
        int exp_q[$];
        int p, stalls, held, head;
        logic [7:0] captured;
        bit done_seen;
        for (int i = 0; i < 8; i++) if (mask[i]) exp_q.push_back(i);
        p = exp_q.size();
        stalls = 0; held = 0; captured = '0; done_seen = 1'b0;
        @(negedge clk);
        inp = in_v; bus.chan_mask = mask; bus.start = 1'b1; bus.sample_ready = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 300 && !done_seen; cyc++) begin
            @(negedge clk);
            bus.start = repulse && (cyc == 3);
            if (repulse) bus.chan_mask = 8'($urandom);
            chk("busy_in_scan", bus.busy, 1'b1);
            if (bus.done) begin
                done_seen = 1'b1;
                chk("done_cycle", cyc, CHAN_CYCLES * p + 1 + stalls);
                chk("samples_left", exp_q.size(), 0);
                chk("frame_final", bus.frame, mask & in_v);
                chk("valid_in_finish", bus.sample_valid, 1'b0);
            end else if (exp_q.size() == 0) begin
                chk("unexpected_activity", {bus.sample_valid, bus.sel}, 32'hFFFF);
            end else begin
                head = exp_q[0];
                chk("sel", bus.sel, head);
                if (bus.sample_valid) begin
                    captured[head] = 1'b1;
                    chk("sample_chan", bus.sample_chan, head);
                    chk("sample_bit", bus.sample_bit, in_v[head]);
                    chk("frame_partial", bus.frame, mask & in_v & captured);
                    if (head == stall_chan && held < 5) begin
                        bus.sample_ready = 1'b0;
                        held++;
                    end else if (rmode == 1) begin
                        bus.sample_ready = ($urandom_range(0, 3) != 0);
                    end else begin
                        bus.sample_ready = 1'b1;
                    end
                    if (bus.sample_ready) void'(exp_q.pop_front());
                    else stalls++;
                end else begin
                    chk("frame_partial", bus.frame, mask & in_v & captured);
                end
            end
        end
        if (!done_seen) chk("done_timeout", 0, 1);
        @(negedge clk);
        bus.start = 1'b0;
        chk("done_one_cycle", bus.done, 1'b0);
        chk("idle_after_done", bus.busy, 1'b0);
        chk("frame_hold", bus.frame, mask & in_v);
    endtask

    // Deterministic scan on the N=2 instance with ready held high.
    task automatic run_scan2(input logic [1:0] mask, input logic [1:0] in_v);
        @(negedge clk);
        inp2 = in_v; bus2.chan_mask = mask; bus2.start = 1'b1; bus2.sample_ready = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 2; c++) begin
            if (mask[c]) begin
                @(negedge clk);
                bus2.start = 1'b0;
                chk("n2_sel", bus2.sel, c);
                @(negedge clk);
                chk("n2_valid", bus2.sample_valid, 1'b1);
                chk("n2_chan", bus2.sample_chan, c);
                chk("n2_bit", bus2.sample_bit, in_v[c]);
            end
        end
        @(negedge clk);
        bus2.start = 1'b0;
        chk("n2_done", bus2.done, 1'b1);
        chk("n2_frame", bus2.frame, mask & in_v);
    endtask

    initial begin
        int wait_cyc;
        tests = 0; fails = 0;
        rst_n = 1'b0; inp = '0; inp2 = '0;
        bus.start = 1'b0; bus.chan_mask = '0; bus.sample_ready = 1'b0;
        bus2.start = 1'b0; bus2.chan_mask = '0; bus2.sample_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sel", bus.sel, 0);
        chk("rst_valid", bus.sample_valid, 0);
        chk("rst_chan", bus.sample_chan, 0);
        chk("rst_bit", bus.sample_bit, 0);
        chk("rst_frame", bus.frame, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst2_frame", bus2.frame, 0);
        rst_n = 1'b1;

        run_scan(8'hFF, 8'hA5, 0, -1, 1'b0);
        run_scan(8'b1001_0010, 8'hFF, 0, -1, 1'b0);
        run_scan(8'h00, 8'hFF, 0, -1, 1'b0);
        run_scan(8'hFF, 8'h3C, 0, 2, 1'b0);
        run_scan(8'hFF, 8'h5A, 0, -1, 1'b1);
        run_scan(8'h80, 8'h80, 0, -1, 1'b0);
        run_scan(8'h01, 8'h01, 0, -1, 1'b0);

        // Reset while channel 3 is being presented.
        @(negedge clk);
        inp = 8'hC3; bus.chan_mask = 8'hFF; bus.start = 1'b1; bus.sample_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        wait_cyc = 0;
        while (!(bus.sample_valid && bus.sample_chan == 3'd3) && wait_cyc < 50) begin
            @(negedge clk);
            wait_cyc++;
        end
        chk("reach_ch3", wait_cyc < 50, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_outputs", {bus.sel, bus.sample_valid, bus.sample_chan, bus.sample_bit,
                               bus.frame, bus.busy, bus.done}, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("midrst_no_done", {bus.done, bus.busy}, 0);
        end
        run_scan(8'hFF, 8'h96, 0, -1, 1'b0);

        for (int r = 0; r < 15; r++) begin
            run_scan(8'($urandom), 8'($urandom), 1, -1, 1'b0);
        end

        run_scan2(2'b10, 2'b10);
        run_scan2(2'b11, 2'b01);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
